imem_boot_loader: RTL and testbench

//  Streams a program image into instruction memory over a valid/ready port while holding the core in reset.

---
 rtl/imem_boot_loader_pkg.sv | 14 +
 rtl/imem_boot_loader.sv | 134 +++++++++++++
 tb/tb_imem_boot_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        INIT,
        LOAD,
        DRAIN,
        FILL,
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Streams a program image into imem over valid/ready, optionally pads with NOPs,
// and holds the core in reset until the image is complete.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned        XLEN       = 32,
    parameter int unsigned        IMEM_DEPTH = 64,
    parameter bit                 FILL_NOP   = 1'b1,
    parameter logic [XLEN-1:0]    NOP_INSTR  = imem_boot_loader_pkg::NOP_INSTR,
    localparam int unsigned       AW         = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_last,
    input  logic            reload,
    output logic            imem_we,
    output logic [AW-1:0]   imem_waddr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            cpu_reset,
    output logic            load_done,
    output logic            load_error,
    output logic [AW:0]     word_count
);

    localparam logic [AW:0]   LAST_CNT  = (AW+1)'(IMEM_DEPTH - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);

    loader_state_t   state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   fptr_q, fptr_d;
    logic            we_d;
    logic [AW-1:0]   waddr_d;
    logic [XLEN-1:0] wdata_d;
    logic            err_d;
    logic            cpu_reset_d;
    logic            done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            count_q    <= '0;
            fptr_q     <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            load_error <= 1'b0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            fptr_q     <= fptr_d;
            imem_we    <= we_d;
            imem_waddr <= waddr_d;
            imem_wdata <= wdata_d;
            load_error <= err_d;
            cpu_reset  <= cpu_reset_d;
            load_done  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        fptr_d   = fptr_q;
        we_d     = 1'b0;
        waddr_d  = imem_waddr;
        wdata_d  = imem_wdata;
        err_d    = load_error;
        ld_ready = 1'b0;

        unique case (state_q)
            INIT: begin
                state_d = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    we_d    = 1'b1;
                    waddr_d = count_q[AW-1:0];
                    wdata_d = ld_data;
                    count_d = count_q + 1'b1;
                    // Fill resumes right after the last streamed word; unused on exact fit.
                    fptr_d  = count_q[AW-1:0] + 1'b1;
                    if (count_q == LAST_CNT) begin
                        if (ld_last) begin
                            state_d = DONE;
                        end else begin
                            state_d = DRAIN;
                            err_d   = 1'b1;
                        end
                    end else if (ld_last) begin
                        state_d = FILL_NOP ? FILL : DONE;
                    end
                end
            end
            DRAIN: begin
                ld_ready = 1'b1;
                if (ld_valid && ld_last) begin
                    state_d = DONE;
                end
            end
            FILL: begin
                we_d    = 1'b1;
                waddr_d = fptr_q;
                wdata_d = NOP_INSTR;
                fptr_d  = fptr_q + 1'b1;
                if (fptr_q == LAST_ADDR) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (reload) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // Core release lags entry into DONE by one cycle, after the final write lands.
        done_d      = (state_q == DONE) && !reload;
        cpu_reset_d = !done_d;
    end

    assign word_count = count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader across three configurations.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic        last = 1'b0;
    logic        reload = 1'b0;
    int          sel = 0;

    always #5 clk = ~clk;

    // u_a: depth 64 with fill; u_b: depth 8 with fill; u_c: depth 8 without fill
    logic ready_a, we_a, crst_a, done_a, err_a;
    logic [5:0] waddr_a; logic [31:0] wdata_a; logic [6:0] wc_a;
    logic ready_b, we_b, crst_b, done_b, err_b;
    logic [2:0] waddr_b; logic [31:0] wdata_b; logic [3:0] wc_b;
    logic ready_c, we_c, crst_c, done_c, err_c;
    logic [2:0] waddr_c; logic [31:0] wdata_c; logic [3:0] wc_c;

    logic valid_a, valid_b, valid_c, reload_a, reload_b, reload_c;
    assign valid_a  = valid  && (sel == 0);
    assign valid_b  = valid  && (sel == 1);
    assign valid_c  = valid  && (sel == 2);
    assign reload_a = reload && (sel == 0);
    assign reload_b = reload && (sel == 1);
    assign reload_c = reload && (sel == 2);

    imem_boot_loader #(.XLEN(32), .IMEM_DEPTH(64), .FILL_NOP(1'b1)) u_a (
        .clk(clk), .reset(reset), .ld_valid(valid_a), .ld_ready(ready_a), .ld_data(data),
        .ld_last(last), .reload(reload_a), .imem_we(we_a), .imem_waddr(waddr_a),
        .imem_wdata(wdata_a), .cpu_reset(crst_a), .load_done(done_a), .load_error(err_a),
        .word_count(wc_a));
    imem_boot_loader #(.XLEN(32), .IMEM_DEPTH(8), .FILL_NOP(1'b1)) u_b (
        .clk(clk), .reset(reset), .ld_valid(valid_b), .ld_ready(ready_b), .ld_data(data),
        .ld_last(last), .reload(reload_b), .imem_we(we_b), .imem_waddr(waddr_b),
        .imem_wdata(wdata_b), .cpu_reset(crst_b), .load_done(done_b), .load_error(err_b),
        .word_count(wc_b));
    imem_boot_loader #(.XLEN(32), .IMEM_DEPTH(8), .FILL_NOP(1'b0)) u_c (
        .clk(clk), .reset(reset), .ld_valid(valid_c), .ld_ready(ready_c), .ld_data(data),
        .ld_last(last), .reload(reload_c), .imem_we(we_c), .imem_waddr(waddr_c),
        .imem_wdata(wdata_c), .cpu_reset(crst_c), .load_done(done_c), .load_error(err_c),
        .word_count(wc_c));

    logic ready_m, we_m, crst_m, done_m, err_m;
    logic [6:0] waddr_m, wc_m;
    logic [31:0] wdata_m;

    always_comb begin
        ready_m = 1'b0; we_m = 1'b0; crst_m = 1'b0; done_m = 1'b0; err_m = 1'b0;
        waddr_m = '0; wc_m = '0; wdata_m = '0;
        case (sel)
            0: begin
                ready_m = ready_a; we_m = we_a; crst_m = crst_a; done_m = done_a; err_m = err_a;
                waddr_m = 7'(waddr_a); wc_m = wc_a; wdata_m = wdata_a;
            end
            1: begin
                ready_m = ready_b; we_m = we_b; crst_m = crst_b; done_m = done_b; err_m = err_b;
                waddr_m = 7'(waddr_b); wc_m = 7'(wc_b); wdata_m = wdata_b;
            end
            default: begin
                ready_m = ready_c; we_m = we_c; crst_m = crst_c; done_m = done_c; err_m = err_c;
                waddr_m = 7'(waddr_c); wc_m = 7'(wc_c); wdata_m = wdata_c;
            end
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    logic [31:0] mem [0:63];
    int wlog [0:127];
    int nwr, last_we_cyc, last_we_addr, fall_cyc, done_cyc, hs_cyc;
    bit fell, done_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and record what the selected DUT did.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (we_m) begin
            mem[waddr_m[5:0]] = wdata_m;
            if (nwr < 128) wlog[nwr] = int'(waddr_m);
            nwr++;
            last_we_cyc  = cyc;
            last_we_addr = int'(waddr_m);
        end
        if (!crst_m && !fell) begin
            fell = 1'b1;
            fall_cyc = cyc;
        end
        if (done_m && !done_seen) begin
            done_seen = 1'b1;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BEEF;
        nwr = 0; fell = 1'b0; done_seen = 1'b0;
        last_we_cyc = -1; last_we_addr = -1; fall_cyc = -1; done_cyc = -1; hs_cyc = -1;
    endtask

    task automatic do_reset(input int s);
        sel = s;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int k;
        k = 0;
        while (!ready_m && k < 20) begin
            tick();
            k++;
        end
        if (!ready_m) begin
            check("ready_timeout", 64'(ready_m), 64'd1);
        end else begin
            valid = 1'b1; data = d; last = l;
            hs_cyc = cyc;
            tick();
            valid = 1'b0; last = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done_m && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(done_m), 64'd1);
    endtask

    int bad;

    initial begin
        clear_log();
        #1 reset = 1'b1;
        // Reset state on every configuration
        for (int s = 0; s < 3; s++) begin
            sel = s;
            tick();
            check("rst_cpu_reset", 64'(crst_m), 64'd1);
            check("rst_ready",     64'(ready_m), 64'd0);
            check("rst_done",      64'(done_m), 64'd0);
            check("rst_err",       64'(err_m), 64'd0);
            check("rst_we",        64'(we_m), 64'd0);
            check("rst_wc",        64'(wc_m), 64'd0);
        end

        // Depth 64 with NOP fill, 3-word image
        do_reset(0);
        send_word(32'h0070_0093, 1'b0);
        send_word(32'h0080_0113, 1'b0);
        send_word(32'h0020_81b3, 1'b1);
        wait_done("t1_done", 200);
        check("t1_mem0", 64'(mem[0]), 64'h0070_0093);
        check("t1_mem1", 64'(mem[1]), 64'h0080_0113);
        check("t1_mem2", 64'(mem[2]), 64'h0020_81b3);
        bad = 0;
        for (int i = 3; i < 64; i++) if (mem[i] !== 32'h0000_0013) bad++;
        check("t1_fill_nops_bad", 64'(bad), 64'd0);
        check("t1_nwrites", 64'(nwr), 64'd64);
        check("t1_last_addr", 64'(last_we_addr), 64'd63);
        check("t1_release_lag", 64'(fall_cyc - last_we_cyc), 64'd1);
        check("t1_wc", 64'(wc_m), 64'd3);
        check("t1_err", 64'(err_m), 64'd0);
        check("t1_ready_done", 64'(ready_m), 64'd0);

        // Valid gaps 1,0,0,1,0,1 on the no-fill instance
        do_reset(2);
        send_word(32'hA000_0001, 1'b0);
        idle(2);
        send_word(32'hA000_0002, 1'b0);
        idle(1);
        send_word(32'hA000_0003, 1'b1);
        wait_done("t2_done", 20);
        check("t2_nwrites", 64'(nwr), 64'd3);
        check("t2_addr0", 64'(wlog[0]), 64'd0);
        check("t2_addr1", 64'(wlog[1]), 64'd1);
        check("t2_addr2", 64'(wlog[2]), 64'd2);
        check("t2_mem2", 64'(mem[2]), 64'hA000_0003);
        check("t2_wc", 64'(wc_m), 64'd3);

        // Single word, no fill: release two cycles after the handshake
        do_reset(2);
        send_word(32'h0010_0093, 1'b1);
        wait_done("t5_done", 20);
        check("t5_nwrites", 64'(nwr), 64'd1);
        check("t5_addr", 64'(wlog[0]), 64'd0);
        check("t5_mem0", 64'(mem[0]), 64'h0010_0093);
        check("t5_release_lag", 64'(fall_cyc - hs_cyc), 64'd2);

        // Depth 8, 10-word image: overflow drained and flagged
        do_reset(1);
        for (int i = 0; i < 10; i++) send_word(32'h0000_1000 + 32'(i), i == 9);
        wait_done("t3_done", 20);
        check("t3_nwrites", 64'(nwr), 64'd8);
        check("t3_mem0", 64'(mem[0]), 64'h1000);
        check("t3_mem7", 64'(mem[7]), 64'h1007);
        check("t3_err", 64'(err_m), 64'd1);
        check("t3_wc", 64'(wc_m), 64'd8);
        check("t3_done_lag", 64'(done_cyc - hs_cyc), 64'd2);

        // Reload from DONE, then a 2-word image
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("t6_cpu_reset", 64'(crst_m), 64'd1);
        check("t6_done", 64'(done_m), 64'd0);
        check("t6_err", 64'(err_m), 64'd0);
        check("t6_wc", 64'(wc_m), 64'd0);
        clear_log();
        send_word(32'hB000_0000, 1'b0);
        send_word(32'hB000_0001, 1'b1);
        wait_done("t6_done_again", 40);
        check("t6_wc2", 64'(wc_m), 64'd2);
        check("t6_mem1", 64'(mem[1]), 64'hB000_0001);
        bad = 0;
        for (int i = 2; i < 8; i++) if (mem[i] !== 32'h0000_0013) bad++;
        check("t6_fill_nops_bad", 64'(bad), 64'd0);
        check("t6_nwrites", 64'(nwr), 64'd8);

        // Reload outside DONE is ignored
        do_reset(1);
        send_word(32'hC000_0000, 1'b0);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("t7_wc_kept", 64'(wc_m), 64'd1);

        // Depth 8 exact fit: no fill, no error
        do_reset(1);
        for (int i = 0; i < 8; i++) send_word(32'h0000_2000 + 32'(i), i == 7);
        wait_done("t4_done", 20);
        check("t4_nwrites", 64'(nwr), 64'd8);
        check("t4_mem7", 64'(mem[7]), 64'h2007);
        check("t4_err", 64'(err_m), 64'd0);
        check("t4_wc", 64'(wc_m), 64'd8);
        check("t4_release_lag", 64'(fall_cyc - last_we_cyc), 64'd1);

        // Async reset mid-stream aborts the load
        do_reset(1);
        send_word(32'hD000_0000, 1'b0);
        send_word(32'hD000_0001, 1'b0);
        check("t8_wc_pre", 64'(wc_m), 64'd2);
        #2 reset = 1'b1;
        #1;
        check("t8_cpu_reset", 64'(crst_m), 64'd1);
        check("t8_ready", 64'(ready_m), 64'd0);
        check("t8_wc", 64'(wc_m), 64'd0);
        check("t8_we", 64'(we_m), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
